// File: rtl/intmul_arb.sv
// Round-robin arbiter sharing one fixed-latency multiplier among NREQ requesters.
// Optional macro INTMUL_ARB_PRIO_EN gives requester 0 strict priority over the rest.
module intmul_arb #(
    parameter int LOGQ    = 32,
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*LOGQ-1:0]          req_a,
    input  logic [NREQ*LOGQ-1:0]          req_b,
    input  logic                          hold,
    output logic [LOGQ-1:0]               mul_a,
    output logic [LOGQ-1:0]               mul_b,
    input  logic [2*LOGQ-1:0]             mul_c,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [2*LOGQ-1:0]             rsp_c,
    output logic [$clog2(MUL_LAT+1)-1:0]  inflight,
    output logic                          idle
);
    localparam int PW = $clog2(NREQ);
    localparam int IW = $clog2(MUL_LAT+1);

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_nxt;
    logic [PW-1:0]       w_gnt_idx;
    logic [PW-1:0]       w_cand;
    logic                w_gnt_found;
    logic                w_issue;
    logic                w_exit;
    logic [MUL_LAT-1:0]  r_pipe_vld;
    logic [PW-1:0]       r_pipe_tag [MUL_LAT];
    logic [IW-1:0]       r_inflight;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [2*LOGQ-1:0]   r_rsp_c;
    logic                r_idle;

    // Search from r_ptr upward, wrapping; first valid requester wins.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        int idx;
        idx         = 0;
        w_cand      = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
`ifdef INTMUL_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_gnt_found = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            w_cand = PW'(idx);
`ifdef INTMUL_ARB_PRIO_EN
            if (!w_gnt_found && (w_cand != '0) && req_valid[w_cand]) begin
`else
            if (!w_gnt_found && req_valid[w_cand]) begin
`endif
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    always_comb begin
        int p;
        p = int'(w_gnt_idx) + 1;
        if (p >= NREQ) begin
            p = 0;
        end
        w_ptr_nxt = PW'(p);
`ifdef INTMUL_ARB_PRIO_EN
        // Priority grants to requester 0 do not disturb the rotation among the others.
        if (w_gnt_idx == '0) begin
            w_ptr_nxt = r_ptr;
        end
`endif
    end

    always_comb begin
        w_issue   = (r_state == RUN) && !rst && w_gnt_found;
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (w_issue) begin
            req_ready[w_gnt_idx] = 1'b1;
            mul_a = req_a[int'(w_gnt_idx)*LOGQ +: LOGQ];
            mul_b = req_b[int'(w_gnt_idx)*LOGQ +: LOGQ];
        end
    end

    assign w_exit = r_pipe_vld[MUL_LAT-1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (hold) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!hold) w_state_nxt = RUN;
                else if (r_inflight == '0) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (!hold) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking '<='; combinational blocks use '='.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_ptr       <= '0;
            r_pipe_vld  <= '0;
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            r_rsp_c     <= '0;
            r_idle      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle     <= (w_state_nxt == IDLE);
            r_pipe_vld <= (r_pipe_vld << 1) | MUL_LAT'(w_issue);
            if (w_issue) begin
                r_ptr <= w_ptr_nxt;
            end
            case ({w_issue, w_exit})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: ;
            endcase
            r_rsp_valid <= '0;
            if (w_exit) begin
                r_rsp_valid <= NREQ'(1) << r_pipe_tag[MUL_LAT-1];
                r_rsp_c     <= mul_c;
            end
        end
    end

    // NOTE: tags are only meaningful alongside r_pipe_vld, so this storage is left unreset.
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= w_gnt_idx;
        for (int k = 1; k < MUL_LAT; k++) begin
            r_pipe_tag[k] <= r_pipe_tag[k-1];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_c     = r_rsp_c;
    assign inflight  = r_inflight;
    assign idle      = r_idle;

endmodule

// File: tb/tb_intmul_arb.sv
// Directed bench for intmul_arb: a 2-requester instance with a modelled multiplier
// and a 3-requester instance for rotation/priority (INTMUL_ARB_PRIO_EN aware).
module tb_intmul_arb;
    logic        clk;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [63:0] req_a, req_b, mul_c, rsp_c;
    logic        hold;
    logic [31:0] mul_a, mul_b;
    logic [1:0]  inflight;
    logic        idle;
    logic [63:0] m_pipe [2];

    logic [2:0]  req_valid3, req_ready3, rsp_valid3;
    logic [95:0] req_a3, req_b3;
    logic [31:0] mul_a3, mul_b3;
    logic [63:0] mul_c3, rsp_c3;
    logic        inflight3;
    logic        idle3;
    logic        hold3;

    int total = 0;
    int bad   = 0;

    intmul_arb #(.LOGQ(32), .NREQ(2), .MUL_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .hold(hold), .mul_a(mul_a), .mul_b(mul_b),
        .mul_c(mul_c), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .inflight(inflight),
        .idle(idle)
    );

    intmul_arb #(.LOGQ(32), .NREQ(3), .MUL_LAT(1)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .hold(hold3), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_c(mul_c3), .rsp_valid(rsp_valid3), .rsp_c(rsp_c3), .inflight(inflight3),
        .idle(idle3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External two-stage multiplier model.
    always @(posedge clk) begin
        m_pipe[0] <= 64'(mul_a) * 64'(mul_b);
        m_pipe[1] <= m_pipe[0];
    end
    assign mul_c  = m_pipe[1];
    assign mul_c3 = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  fair_gnt  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] fair_mula [6] = '{32'd10, 32'd101, 32'd12, 32'd103, 32'd14, 32'd105};
    logic [63:0] fair_prod [6] = '{64'd20, 64'd303, 64'd24, 64'd309, 64'd28, 64'd315};
`ifdef INTMUL_ARB_PRIO_EN
    logic [2:0]  g3 [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [31:0] a3 [6] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10};
    logic [31:0] b3 [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
`else
    logic [2:0]  g3 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [31:0] a3 [6] = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30};
    logic [31:0] b3 [6] = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3};
`endif

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        hold3 = 1'b0; req_valid3 = '0;
        req_a3 = {32'd30, 32'd20, 32'd10};
        req_b3 = {32'd3, 32'd2, 32'd1};
        tick();
        req_valid = 2'b01; #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_c", rsp_c, 64'd0);
        check("rst_inflight", inflight, 2'd0);
        check("rst_idle", idle, 1'b0);
        tick();
        rst = 1'b0; req_valid = '0;

        // Single requester: 3*5 appears three cycles after issue.
        req_valid = 2'b01; req_a = {32'd0, 32'd3}; req_b = {32'd0, 32'd5}; #1;
        check("single_ready", req_ready, 2'b01);
        check("single_mul_a", mul_a, 32'd3);
        check("single_mul_b", mul_b, 32'd5);
        tick();
        req_valid = '0; #1;
        check("single_ready_off", req_ready, 2'b00);
        check("single_mul_a_zero", mul_a, 32'd0);
        check("single_inflight1", inflight, 2'd1);
        tick(); #1;
        check("single_no_rsp_early", rsp_valid, 2'b00);
        check("single_inflight1b", inflight, 2'd1);
        tick(); #1;
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_rsp_c", rsp_c, 64'd15);
        check("single_inflight0", inflight, 2'd0);
        tick(); #1;
        check("single_rsp_off", rsp_valid, 2'b00);
        check("single_rsp_c_hold", rsp_c, 64'd15);

        // Reset one cycle after an issue from requester 1 (pointer now at 1).
        req_valid = 2'b10; req_a = {32'd7, 32'd0}; req_b = {32'd9, 32'd0}; #1;
        check("rr_ptr_ready", req_ready, 2'b10);
        tick();
        req_valid = '0; rst = 1'b1; #1;
        check("rst_mid_ready", req_ready, 2'b00);
        tick();
        rst = 1'b0; #1;
        check("rst_mid_inflight", inflight, 2'd0);
        check("rst_mid_rsp_c", rsp_c, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_rsp", rsp_valid, 2'b00);
            tick();
        end

        // Fairness: both requesters valid for six cycles.
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                req_valid = 2'b11;
                req_a = {32'(100 + c), 32'(10 + c)};
                req_b = {32'd3, 32'd2};
            end else begin
                req_valid = '0;
            end
            #1;
            if (c < 6) begin
                check("fair_grant", req_ready, fair_gnt[c]);
                check("fair_mul_a", mul_a, fair_mula[c]);
            end
            if (c >= 2 && c <= 6) check("fair_inflight_max", inflight, 2'd2);
            if (c >= 3) begin
                check("fair_rsp_valid", rsp_valid, fair_gnt[c-3]);
                check("fair_rsp_c", rsp_c, fair_prod[c-3]);
            end
            tick();
        end

        // Drain: hold rises together with the second issue.
        req_valid = 2'b11; req_a = {32'd6, 32'd4}; req_b = {32'd7, 32'd5}; #1;
        check("drain_grant0", req_ready, 2'b01);
        tick();
        hold = 1'b1; #1;
        check("drain_hold_edge_issue", req_ready, 2'b10);
        tick(); #1;
        check("drain_no_grant_a", req_ready, 2'b00);
        check("drain_inflight2", inflight, 2'd2);
        check("drain_idle0_a", idle, 1'b0);
        tick(); #1;
        check("drain_no_grant_b", req_ready, 2'b00);
        check("drain_inflight1", inflight, 2'd1);
        check("drain_rsp0", rsp_valid, 2'b01);
        check("drain_rsp0_c", rsp_c, 64'd20);
        tick(); #1;
        check("drain_no_grant_c", req_ready, 2'b00);
        check("drain_inflight0", inflight, 2'd0);
        check("drain_idle0_b", idle, 1'b0);
        check("drain_rsp1", rsp_valid, 2'b10);
        check("drain_rsp1_c", rsp_c, 64'd42);
        tick(); #1;
        check("drain_idle1", idle, 1'b1);
        hold = 1'b0; req_valid = 2'b01;
        req_a = {32'd0, 32'hFFFF_FFFF}; req_b = {32'd0, 32'hFFFF_FFFF}; #1;
        check("idle_no_grant", req_ready, 2'b00);
        tick(); #1;
        check("resume_grant", req_ready, 2'b01);
        check("resume_idle0", idle, 1'b0);
        check("full_mul_a", mul_a, 32'hFFFF_FFFF);
        tick();
        req_valid = '0;
        tick();
        tick(); #1;
        check("full_rsp_valid", rsp_valid, 2'b01);
        check("full_rsp_c", rsp_c, 64'hFFFF_FFFE_0000_0001);

        // Three requesters, single-cycle multiplier, all valid.
        for (int c = 0; c < 8; c++) begin
            req_valid3 = (c < 6) ? 3'b111 : 3'b000;
            #1;
            if (c < 6) begin
                check("three_grant", req_ready3, g3[c]);
                check("three_mul_a", mul_a3, a3[c]);
                check("three_mul_b", mul_b3, b3[c]);
            end
            if (c >= 1 && c <= 6) check("three_inflight_max", inflight3, 1'b1);
            if (c >= 2) begin
                check("three_rsp_valid", rsp_valid3, g3[c-2]);
                check("three_rsp_c", rsp_c3, 64'd0);
            end
            check("three_idle", idle3, 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
